// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS datapath and its main control FSM.
// Latency: none (wires only).
// Backpressure: none; the controller advances one state per clock unconditionally.
//
// Ports (as seen by the controller, modport slave):
//   in  Op[5:0]       IR[31:26]
//   in  Funct[5:0]    IR[5:0], used only to spot jr/jalr
//   in  Zero          ALU zero flag
//   out PCWrite, IRWrite, MemRead, MemWrite, RegWrite   datapath strobes
//   out ALUOp[3:0]    to the ALU control decoder
//   out ALUSrcA, ALUSrcB[1:0], EXTOp, RegDst[1:0], WDSel[1:0], PCSource[1:0]
//   out state[3:0]    current FSM state, debug only
//   out illegal       unsupported opcode seen in DECODE
interface mc_ctrl_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [3:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       EXTOp;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal;

  // Datapath side: presents the IR fields and flags, consumes the controls.
  modport master (
    output Op, Funct, Zero,
    input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUOp, ALUSrcA,
           ALUSrcB, EXTOp, RegDst, WDSel, PCSource, state, illegal
  );

  // Controller side.
  modport slave (
    input  Op, Funct, Zero,
    output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUOp, ALUSrcA,
           ALUSrcB, EXTOp, RegDst, WDSel, PCSource, state, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control: sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath control.
// Latency: Moore outputs from the state register; 2..5 cycles per instruction (BRANCH PCWrite also uses Zero).
// Backpressure: none; one state per clock, asynchronous active-low reset forces FETCH and kills strobes.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   ctl   mc_ctrl_fsm_if.slave: Op/Funct/Zero in, all control outputs out
module mc_ctrl_fsm (
  input  logic         clk,
  input  logic         rstn,
  mc_ctrl_fsm_if.slave ctl
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    EXEC_I = 4'd10,
    IWB    = 4'd11,
    JREG   = 4'd12
  } state_e;

  // ALUOp encodings
  localparam logic [3:0] ALUOP_LS    = 4'b0000;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0001;
  localparam logic [3:0] ALUOP_ADDI  = 4'b0010;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0011;
  localparam logic [3:0] ALUOP_ORI   = 4'b0100;
  localparam logic [3:0] ALUOP_XORI  = 4'b0101;
  localparam logic [3:0] ALUOP_SLTI  = 4'b0110;
  localparam logic [3:0] ALUOP_SLTIU = 4'b0111;
  localparam logic [3:0] ALUOP_LUI   = 4'b1000;
  localparam logic [3:0] ALUOP_BEQ   = 4'b1001;
  localparam logic [3:0] ALUOP_BNE   = 4'b1010;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  state_e state_q, state_d;

  // Opcode classification; only consulted after FETCH, when the IR is stable.
  logic       is_load, is_store, is_imm;
  logic [3:0] imm_aluop;
  logic       imm_ext;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_imm    = 1'b0;
    imm_aluop = ALUOP_ADDI;
    imm_ext   = 1'b1;
    case (ctl.Op)
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: is_load = 1'b1;
      OP_SW, OP_SB, OP_SH:                 is_store = 1'b1;
      OP_ADDI, OP_ADDIU: begin is_imm = 1'b1; imm_aluop = ALUOP_ADDI; end
      OP_ANDI:  begin is_imm = 1'b1; imm_aluop = ALUOP_ANDI;  imm_ext = 1'b0; end
      OP_ORI:   begin is_imm = 1'b1; imm_aluop = ALUOP_ORI;   imm_ext = 1'b0; end
      OP_XORI:  begin is_imm = 1'b1; imm_aluop = ALUOP_XORI;  imm_ext = 1'b0; end
      OP_SLTI:  begin is_imm = 1'b1; imm_aluop = ALUOP_SLTI;  end
      OP_SLTIU: begin is_imm = 1'b1; imm_aluop = ALUOP_SLTIU; end
      OP_LUI:   begin is_imm = 1'b1; imm_aluop = ALUOP_LUI;   imm_ext = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Raw (ungated) control values; strobes are qualified by rstn below.
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, illegal;
  logic [3:0] alu_op;
  logic       alu_src_a, ext_op;
  logic [1:0] alu_src_b, reg_dst, wd_sel, pc_source;

  always_comb begin
    state_d   = FETCH;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    alu_op    = ALUOP_LS;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    ext_op    = 1'b1;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    pc_source = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = DECODE;
      end
      DECODE: begin
        // Speculatively form PC + (imm << 2) for a possible branch.
        alu_src_b = 2'b11;
        if (ctl.Op == OP_RTYPE)
          state_d = (ctl.Funct == FN_JR || ctl.Funct == FN_JALR) ? JREG : EXEC_R;
        else if (is_load || is_store)
          state_d = MEMADR;
        else if (ctl.Op == OP_BEQ || ctl.Op == OP_BNE)
          state_d = BRANCH;
        else if (ctl.Op == OP_J || ctl.Op == OP_JAL)
          state_d = JUMP;
        else if (is_imm)
          state_d = EXEC_I;
        else
          illegal = 1'b1;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_store ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        state_d  = MEMWB;
      end
      MEMWB: begin
        reg_write = 1'b1;
        wd_sel    = 2'b01;
      end
      MEMWR: mem_write = 1'b1;
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
        state_d   = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        pc_source = 2'b01;
        if (ctl.Op == OP_BNE) begin
          alu_op   = ALUOP_BNE;
          pc_write = ~ctl.Zero;
        end else begin
          alu_op   = ALUOP_BEQ;
          pc_write = ctl.Zero;
        end
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        if (ctl.Op == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          wd_sel    = 2'b10;
        end
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_aluop;
        ext_op    = imm_ext;
        state_d   = IWB;
      end
      IWB: begin
        // Extension is re-derived from the unchanged IR so the write-back
        // sees the same immediate EXEC_I used.
        reg_write = 1'b1;
        ext_op    = imm_ext;
      end
      JREG: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        if (ctl.Funct == FN_JALR) begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          wd_sel    = 2'b10;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes are killed combinationally by reset so no write can slip out
  // between reset assertion and the state register settling.
  assign ctl.PCWrite  = pc_write  & rstn;
  assign ctl.IRWrite  = ir_write  & rstn;
  assign ctl.MemRead  = mem_read  & rstn;
  assign ctl.MemWrite = mem_write & rstn;
  assign ctl.RegWrite = reg_write & rstn;
  assign ctl.illegal  = illegal   & rstn;
  assign ctl.ALUOp    = alu_op;
  assign ctl.ALUSrcA  = alu_src_a;
  assign ctl.ALUSrcB  = alu_src_b;
  assign ctl.EXTOp    = ext_op;
  assign ctl.RegDst   = reg_dst;
  assign ctl.WDSel    = wd_sel;
  assign ctl.PCSource = pc_source;
  assign ctl.state    = state_q;

endmodule
